// File: rtl/pc060ha_pkg.sv
// Shared types and defaults for the PC060HA bus sequencers.
package pc060ha_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPSu,
        StPStb,
        StPHld,
        StGap,
        StDSu,
        StDStb,
        StDHld
    } seqState;

    typedef logic [3:0] nibble;
    typedef logic [3:0] pageNum;

    localparam int unsigned DefTSu  = 1;
    localparam int unsigned DefTStb = 2;
    localparam int unsigned DefTHld = 1;

    // A phase of t cycles loads t-1 so that it ends on the zero count.
    function automatic logic [2:0] phaseLoad(input int unsigned t);
        return 3'(t - 1);
    endfunction

endpackage

// File: rtl/pc060ha_phase_timer.sv
// Loadable 3-bit down-counter with a zero flag; holds at zero.
module pc060ha_phase_timer (
    input  logic       clk,
    input  logic       rstN,
    input  logic       load,
    input  logic [2:0] loadVal,
    output logic       zero
);

    logic [2:0] cntQ;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cntQ <= '0;
        end else if (load) begin
            cntQ <= loadVal;
        end else if (cntQ != '0) begin
            cntQ <= cntQ - 3'd1;
        end
    end

    assign zero = (cntQ == '0);

endmodule

// File: rtl/pc060ha_master_seq.sv
// PC060HA master-port sequencer: page write then data write/read, with a one-entry page cache.
module pc060ha_master_seq
    import pc060ha_pkg::*;
#(
    parameter int unsigned T_SU       = DefTSu,
    parameter int unsigned T_STB      = DefTStb,
    parameter int unsigned T_HLD      = DefTHld,
    parameter int unsigned PAGE_CACHE = 1
) (
    input  logic       MCLK,
    input  logic       nIC,
    input  logic       REQ,
    input  logic       WR,
    input  logic [3:0] PAGE,
    input  logic [3:0] WDATA,
    input  logic       INVAL,
    output logic       READY,
    output logic       DONE,
    output logic [3:0] RDATA,
    output logic       nMCS,
    output logic       nMWR,
    output logic       nMRD,
    output logic       MA0,
    output logic [3:0] MD_O,
    output logic       MD_OE,
    input  logic [3:0] MD_I
);

    localparam logic [2:0] SuLoad  = phaseLoad(T_SU);
    localparam logic [2:0] StbLoad = phaseLoad(T_STB);
    localparam logic [2:0] HldLoad = phaseLoad(T_HLD);

    seqState stateQ, stateD;
    logic    wrQ, wrD;
    pageNum  pageQ, pageD, cachePageQ;
    nibble   dataQ, dataD, mdOD;
    logic    cacheValidQ;
    logic    accept, hit, tmrLoad, tmrZero, setValid, capture, doneD;
    logic    nMcsD, nMwrD, nMrdD, ma0D, mdOeD;
    logic [2:0] tmrLoadVal;

    assign accept = REQ && (stateQ == StIdle);
    // INVAL on the accept edge must force the page cycle.
    assign hit = (PAGE_CACHE != 0) && cacheValidQ && !INVAL && (PAGE == cachePageQ);

    pc060ha_phase_timer uTimer (
        .clk     (MCLK),
        .rstN    (nIC),
        .load    (tmrLoad),
        .loadVal (tmrLoadVal),
        .zero    (tmrZero)
    );

    always_comb begin
        stateD     = stateQ;
        tmrLoad    = 1'b0;
        tmrLoadVal = '0;
        setValid   = 1'b0;
        capture    = 1'b0;
        doneD      = 1'b0;
        wrD        = accept ? WR : wrQ;
        pageD      = accept ? PAGE : pageQ;
        dataD      = accept ? WDATA : dataQ;
        unique case (stateQ)
            StIdle: if (accept) begin
                stateD = hit ? StDSu : StPSu;
                tmrLoad = 1'b1; tmrLoadVal = SuLoad;
            end
            StPSu:  if (tmrZero) begin stateD = StPStb; tmrLoad = 1'b1; tmrLoadVal = StbLoad; end
            StPStb: if (tmrZero) begin stateD = StPHld; tmrLoad = 1'b1; tmrLoadVal = HldLoad; end
            StPHld: if (tmrZero) begin stateD = StGap; tmrLoad = 1'b1; setValid = 1'b1; end
            StGap:  if (tmrZero) begin stateD = StDSu; tmrLoad = 1'b1; tmrLoadVal = SuLoad; end
            StDSu:  if (tmrZero) begin stateD = StDStb; tmrLoad = 1'b1; tmrLoadVal = StbLoad; end
            StDStb: if (tmrZero) begin
                stateD = StDHld;
                tmrLoad = 1'b1; tmrLoadVal = HldLoad;
                capture = !wrQ;
            end
            StDHld: if (tmrZero) begin stateD = StIdle; doneD = 1'b1; end
            default: stateD = StIdle;
        endcase
    end

    // Bus outputs are decoded from the next state so they can be registered.
    always_comb begin
        nMcsD = 1'b1;
        nMwrD = 1'b1;
        nMrdD = 1'b1;
        ma0D  = 1'b1;
        mdOeD = 1'b0;
        mdOD  = '0;
        case (stateD)
            StPSu, StPStb, StPHld: begin
                nMcsD = 1'b0;
                ma0D  = 1'b0;
                mdOeD = 1'b1;
                mdOD  = pageD;
                nMwrD = (stateD != StPStb);
            end
            StDSu, StDStb, StDHld: begin
                nMcsD = 1'b0;
                mdOeD = wrD;
                mdOD  = wrD ? dataD : '0;
                nMwrD = !((stateD == StDStb) && wrD);
                nMrdD = !((stateD == StDStb) && !wrD);
            end
            default: ;
        endcase
    end

    always_ff @(posedge MCLK or negedge nIC) begin
        if (!nIC) begin
            stateQ      <= StIdle;
            wrQ         <= 1'b0;
            pageQ       <= '0;
            dataQ       <= '0;
            cacheValidQ <= 1'b0;
            cachePageQ  <= '0;
            READY       <= 1'b1;
            DONE        <= 1'b0;
            RDATA       <= '0;
            nMCS        <= 1'b1;
            nMWR        <= 1'b1;
            nMRD        <= 1'b1;
            MA0         <= 1'b1;
            MD_O        <= '0;
            MD_OE       <= 1'b0;
        end else begin
            stateQ <= stateD;
            wrQ    <= wrD;
            pageQ  <= pageD;
            dataQ  <= dataD;
            if (INVAL) begin
                cacheValidQ <= 1'b0;
            end else if (setValid) begin
                cacheValidQ <= 1'b1;
                cachePageQ  <= pageQ;
            end
            if (capture) begin
                RDATA <= MD_I;
            end
            READY <= (stateD == StIdle);
            DONE  <= doneD;
            nMCS  <= nMcsD;
            nMWR  <= nMwrD;
            nMRD  <= nMrdD;
            MA0   <= ma0D;
            MD_O  <= mdOD;
            MD_OE <= mdOeD;
        end
    end

endmodule

// File: tb/tb_pc060ha_master_seq.sv
// Directed bench for pc060ha_master_seq: default-timing and stretched-timing instances.
module tb_pc060ha_master_seq;

    logic       MCLK = 1'b0;
    logic       nIC = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, WR = 1'b0, INVAL = 1'b0;
    logic [3:0] PAGE = '0, WDATA = '0, MD_I = '0;

    logic       ready0, done0, nmcs0, nmwr0, nmrd0, ma00, oe0;
    logic [3:0] rdata0, mdo0;
    logic       ready1, done1, nmcs1, nmwr1, nmrd1, ma01, oe1;
    logic [3:0] rdata1, mdo1;

    int nChecks = 0;
    int nFails  = 0;
    logic [3:0] sbq[$];
    logic [3:0] lastRd[2];

    always #5 MCLK = ~MCLK;

    pc060ha_master_seq dut0 (
        .MCLK (MCLK), .nIC (nIC), .REQ (req0), .WR (WR), .PAGE (PAGE), .WDATA (WDATA),
        .INVAL (INVAL), .READY (ready0), .DONE (done0), .RDATA (rdata0), .nMCS (nmcs0),
        .nMWR (nmwr0), .nMRD (nmrd0), .MA0 (ma00), .MD_O (mdo0), .MD_OE (oe0), .MD_I (MD_I)
    );

    pc060ha_master_seq #(.T_SU(2), .T_STB(3), .T_HLD(2), .PAGE_CACHE(1)) dut1 (
        .MCLK (MCLK), .nIC (nIC), .REQ (req1), .WR (WR), .PAGE (PAGE), .WDATA (WDATA),
        .INVAL (INVAL), .READY (ready1), .DONE (done1), .RDATA (rdata1), .nMCS (nmcs1),
        .nMWR (nmwr1), .nMRD (nmrd1), .MA0 (ma01), .MD_O (mdo1), .MD_OE (oe1), .MD_I (MD_I)
    );

    // {READY, DONE, nMCS, nMWR, nMRD, MA0, MD_OE, MD_O}
    function automatic logic [10:0] obs(input int sel);
        if (sel != 0) return {ready1, done1, nmcs1, nmwr1, nmrd1, ma01, oe1, mdo1};
        return {ready0, done0, nmcs0, nmwr0, nmrd0, ma00, oe0, mdo0};
    endfunction

    function automatic logic [3:0] rdOf(input int sel);
        return (sel != 0) ? rdata1 : rdata0;
    endfunction

    task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] exp);
        nChecks++;
        assert (got === exp) else begin
            nFails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One complete access with a cycle-by-cycle model of the bus.
    task automatic access(input int sel, input logic wr, input logic [3:0] pg,
                          input logic [3:0] dt, input logic [3:0] mdi, input bit hit,
                          input bit inv, input string tag);
        int su, stb, hld, p, l, o;
        bit gap, inPage, inData, strobe;
        logic [10:0] exp, mask;
        logic [3:0] expRd;
        su  = (sel != 0) ? 2 : 1;
        stb = (sel != 0) ? 3 : 2;
        hld = (sel != 0) ? 2 : 1;
        p   = su + stb + hld;
        l   = hit ? p : 2 * p + 1;
        @(negedge MCLK);
        WR = wr; PAGE = pg; WDATA = dt; INVAL = inv;
        if (sel != 0) req1 = 1'b1; else req0 = 1'b1;
        if (!wr) lastRd[sel] = mdi;
        sbq.push_back(lastRd[sel]);
        @(posedge MCLK);
        #1;
        req0 = 1'b0; req1 = 1'b0; INVAL = 1'b0;
        for (int c = 0; c <= l; c++) begin
            if (c > 0) begin
                @(posedge MCLK);
                #1;
            end
            gap    = !hit && (c == p);
            inPage = !hit && (c < p);
            inData = (c < l) && !gap && !inPage;
            o      = inPage ? c : (hit ? c : c - p - 1);
            strobe = (inPage || inData) && (o >= su) && (o < su + stb);
            exp = {c == l, c == l, !(inPage || inData), !(strobe && (inPage || wr)),
                   !(strobe && inData && !wr), inData, inPage || (inData && wr),
                   inPage ? pg : dt};
            mask = 11'h7ff;
            if (exp[8]) mask[5] = 1'b0;
            if (!exp[4]) mask[3:0] = 4'h0;
            chk($sformatf("%s c%0d", tag, c), obs(sel) & mask, exp & mask);
            MD_I = (inData && strobe) ? mdi : 4'h5;
            if (c == l) begin
                expRd = sbq.pop_front();
                chk({tag, " rdata"}, {7'h0, rdOf(sel)}, {7'h0, expRd});
            end
        end
    endtask

    initial begin
        logic [10:0] rstVal;
        int doneCnt;
        rstVal = {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0};
        lastRd[0] = 4'h0;
        lastRd[1] = 4'h0;
        repeat (2) @(posedge MCLK);
        #1;
        chk("reset dut0", obs(0), rstVal);
        chk("reset dut1", obs(1), rstVal);
        chk("reset rdata", {3'h0, rdata0, rdata1}, 11'h0);
        @(negedge MCLK);
        nIC = 1'b1;

        access(0, 1'b1, 4'h6, 4'h1, 4'h0, 1'b0, 1'b0, "wr_p6");
        access(0, 1'b1, 4'h6, 4'h7, 4'h0, 1'b1, 1'b0, "wr_hit");
        access(0, 1'b1, 4'h6, 4'h7, 4'h0, 1'b0, 1'b1, "wr_inval");
        access(0, 1'b0, 4'h1, 4'h0, 4'ha, 1'b0, 1'b0, "rd_p1");
        access(0, 1'b1, 4'h1, 4'h3, 4'h0, 1'b1, 1'b0, "wr_after_rd");

        // REQ held high: three cache hits accepted at E0, E5, E10.
        @(negedge MCLK);
        WR = 1'b1; PAGE = 4'h1; WDATA = 4'h9; req0 = 1'b1;
        doneCnt = 0;
        for (int c = 0; c <= 20; c++) begin
            @(posedge MCLK);
            #1;
            if (c == 10) req0 = 1'b0;
            if (done0) doneCnt++;
            chk($sformatf("held c%0d", c), {8'h0, ready0, done0, nmcs0},
                {8'h0, (c % 5 == 4) || (c >= 14), (c == 4) || (c == 9) || (c == 14),
                 (c % 5 == 4) || (c >= 14)});
        end
        chk("held done count", 11'(doneCnt), 11'd3);

        // Reset pulse while the page strobe is active.
        @(negedge MCLK);
        WR = 1'b1; PAGE = 4'h3; WDATA = 4'h2; req0 = 1'b1;
        @(posedge MCLK);
        #1;
        req0 = 1'b0;
        @(posedge MCLK);
        #1;
        chk("abort in strobe", {10'h0, nmwr0}, 11'h0);
        #2;
        nIC = 1'b0;
        #1;
        chk("abort async", obs(0), rstVal);
        lastRd[0] = 4'h0;
        lastRd[1] = 4'h0;
        @(negedge MCLK);
        nIC = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge MCLK);
            #1;
            chk($sformatf("abort idle c%0d", c), {8'h0, done0, ready0, nmcs0}, 11'b011);
        end
        access(0, 1'b1, 4'h1, 4'h5, 4'h0, 1'b0, 1'b0, "wr_after_rst");

        access(1, 1'b1, 4'h2, 4'hc, 4'h0, 1'b0, 1'b0, "par_wr_miss");
        access(1, 1'b0, 4'h2, 4'h0, 4'h7, 1'b1, 1'b0, "par_rd_hit");

        chk("scoreboard empty", 11'(sbq.size()), 11'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/pc060ha_master_seq.md
# pc060ha_master_seq

Upstream bus sequencer for the PC060HA master port. It turns single-cycle nibble-register requests from main-CPU glue logic into correctly timed PC060HA master-side cycles. Each access is a page-register write (MA0=0) followed by a data write or read (MA0=1), with programmable setup, strobe and hold phases. A one-entry page cache skips redundant page writes.

## Interface
Parameters:
- T_SU, 1, setup cycles: nMCS low and MA0/MD valid before the strobe; range 1..7
- T_STB, 2, strobe-low cycles (nMWR or nMRD); range 1..7
- T_HLD, 1, hold cycles: strobe high, nMCS and MD still held; range 1..7
- PAGE_CACHE, 1, 1 = skip the page cycle when PAGE equals the cached page

Ports:
- MCLK  in  1  master clock; all state on rising edge
- nIC  in  1  reset, asynchronous, active-low
- REQ  in  1  request strobe; accepted on the edge where REQ & READY
- WR  in  1  1 = data write, 0 = data read
- PAGE  in  4  page register value for this access
- WDATA  in  4  write nibble
- INVAL  in  1  invalidate page cache
- READY  out  1  idle, can accept a request
- DONE  out  1  one-cycle completion pulse
- RDATA  out  4  last read nibble
- nMCS  out  1  to PC060HA nMCS
- nMWR  out  1  to PC060HA nMWR
- nMRD  out  1  to PC060HA nMRD
- MA0  out  1  to PC060HA MA0
- MD_O  out  4  MD drive value
- MD_OE  out  1  MD tristate enable; the top level builds the inout
- MD_I  in  4  MD sampled value

## Operation
- States: IDLE, P_SU, P_STB, P_HLD, GAP, D_SU, D_STB, D_HLD.
- On acceptance, PAGE, WDATA and WR are latched. The next state is P_SU, or D_SU when PAGE_CACHE=1, the cache is valid and PAGE equals the cached page.
- Page phase: MA0=0, MD_O=page, MD_OE=1, nMCS=0. nMWR=0 only in P_STB.
- GAP: one cycle with nMCS=1, MD_OE=0.
- Data phase: MA0=1, nMCS=0.
  - Write: MD_O=data and MD_OE=1 for all D_* states; nMWR=0 in D_STB.
  - Read: MD_OE=0; nMRD=0 in D_STB.
- Cache: set valid with the latched page at the end of P_HLD.
- INVAL clears cache valid on any edge. When INVAL and an accepting REQ share an edge, the invalidate takes effect first, so the page cycle is issued.
- READY=1 only in IDLE. REQ is ignored while READY=0.
- Phase counter: 3 bits; loads (T_x − 1) on phase entry and advances the state at 0.

## Timing
- Reset values: READY=1, DONE=0, RDATA=0, nMCS=nMWR=nMRD=1, MA0=1, MD_O=0, MD_OE=0, cache invalid, state IDLE.
- All bus outputs are registered, with no combinational path from REQ.
- Acceptance on edge E0. With defaults, the bus sequence after E0 is:
  - P_SU 1 cycle
  - P_STB 2 cycles
  - P_HLD 1 cycle
  - GAP 1 cycle
  - D_SU 1 cycle
  - D_STB 2 cycles
  - D_HLD 1 cycle
- Latency: DONE=1 and READY=1 after edge E(2·(T_SU+T_STB+T_HLD)+1), i.e. E9 with defaults. A cache hit gives E(T_SU+T_STB+T_HLD) = E4.
- Read sampling: MD_I is captured into RDATA on the edge that ends the last D_STB cycle. RDATA is stable from that edge until the next read capture.
- Back-to-back requests: the earliest next acceptance is the edge after DONE, so nMCS is high for at least 1 cycle between accesses.
- nIC low mid-access: all outputs return to reset values immediately and asynchronously, with no DONE. The in-flight access is lost.

## Structure
- Shared package pc060ha_pkg:
  - state enum
  - default T_SU/T_STB/T_HLD constants
  - 4-bit nibble and page typedefs
- Sub-module pc060ha_phase_timer: loadable 3-bit down-counter with a zero flag, reusable by the slave-side sequencer.
- Top level owns the MD inout: MD = MD_OE ? MD_O : 4'bz.

## Test plan
- Reset release, then write PAGE=6 WDATA=1 -> MA0=0/MD=6 write strobe for 2 cycles, 1-cycle nMCS high gap, MA0=1/MD=1 write strobe, DONE at E9.
- Write PAGE=6 WDATA=7 right after the previous access -> no page cycle, DONE at E4. Repeat with INVAL asserted on the accept edge -> page cycle issued, DONE at E9.
- Read PAGE=1 with MD_I=4'hA during D_STB -> nMRD low 2 cycles, MD_OE=0 for the whole data phase, RDATA=4'hA at DONE, unchanged through a following write.
- REQ held high continuously for 3 requests -> each accepted only when READY=1, nMCS high ≥1 cycle between accesses, exactly 3 DONE pulses.
- nIC pulsed low during P_STB -> nMWR/nMCS high and MD_OE=0 immediately, no DONE, next write performs a page cycle (cache invalid).
- Parameters T_SU=2, T_STB=3, T_HLD=2 -> phase lengths match exactly, DONE at E15 for an uncached write.
